// File: rtl/imem_loader.sv
// imem_loader: packs a valid/ready byte stream into 32-bit little-endian words
// and writes them to consecutive instruction memory addresses.
//
//   state | meaning
//   IDLE  | waiting for start; counters hold, all strobes low
//   RECV  | accepting bytes into lanes 0..3 of the word buffer
//   WRITE | one-cycle write of the assembled word
//   DONE  | one-cycle completion pulse, then back to IDLE
module imem_loader #(
  parameter int pos      = 1024,
  parameter int num_bits = 32
) (
  input  logic                   CLK,
  input  logic                   RST_n,
  input  logic                   start,
  input  logic [$clog2(pos)-1:0] base_addr,
  input  logic [$clog2(pos):0]   n_words,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic                   we,
  output logic [$clog2(pos)-1:0] waddr,
  output logic [num_bits-1:0]    wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int            AW        = $clog2(pos);
  localparam logic [AW:0]   POS_W     = (AW+1)'(pos);
  localparam logic [AW:0]   WORD_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(pos - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]       addr_cnt;
  logic [AW:0]         word_cnt;
  logic [1:0]          lane;
  logic [num_bits-1:0] word_buf;
  logic                err_q;
  logic                load;
  logic                accept;

  assign load   = (state == IDLE) && start;
  assign accept = (state == RECV) && byte_valid;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (n_words == '0) ? DONE : RECV;
      end
      RECV: begin
        if (accept && (lane == 2'd3)) state_nxt = WRITE;
      end
      WRITE: begin
        // word_cnt is the count before this write's decrement takes effect
        state_nxt = (word_cnt == WORD_ONE) ? DONE : RECV;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    we         = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  ;
      RECV:  begin byte_ready = 1'b1; busy = 1'b1; end
      WRITE: begin we = 1'b1;         busy = 1'b1; end
      DONE:  begin done = 1'b1;       busy = 1'b1; end
      default: ;
    endcase
  end

  // Oversized requests are clamped to the full memory and flagged.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      addr_cnt <= '0;
      word_cnt <= '0;
      err_q    <= 1'b0;
    end else if (load) begin
      addr_cnt <= base_addr;
      word_cnt <= (n_words > POS_W) ? POS_W : n_words;
      err_q    <= (n_words > POS_W);
    end else if (state == WRITE) begin
      addr_cnt <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + ADDR_ONE;
      word_cnt <= word_cnt - WORD_ONE;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      lane     <= 2'd0;
      word_buf <= '0;
    end else if (load) begin
      lane <= 2'd0;
    end else if (accept) begin
      case (lane)
        2'd0: word_buf[7:0]   <= byte_in;
        2'd1: word_buf[15:8]  <= byte_in;
        2'd2: word_buf[23:16] <= byte_in;
        2'd3: word_buf[31:24] <= byte_in;
        default: ;
      endcase
      lane <= lane + 2'd1;
    end
  end

  assign waddr = addr_cnt;
  assign wdata = word_buf;
  assign err   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random loads compared against a
// word-level model of the expected memory writes and strobe timing.
module tb_imem_loader;

  localparam int POS = 1024;
  localparam int AW  = $clog2(POS);

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   n_words = '0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready, we, busy, done, err;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int          we_cyc[$];
  int          we_addr[$];
  logic [31:0] we_data[$];
  int          done_cyc[$];
  logic [7:0]  stim[$];

  imem_loader #(.pos(POS), .num_bits(32)) dut (
    .CLK(CLK), .RST_n(RST_n), .start(start), .base_addr(base_addr),
    .n_words(n_words), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (we === 1'b1) begin
      we_cyc.push_back(cyc);
      we_addr.push_back(int'(waddr));
      we_data.push_back(wdata);
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    we_cyc.delete(); we_addr.delete(); we_data.delete(); done_cyc.delete();
  endtask

  // Runs one load; stim supplies the bytes or is filled randomly when empty.
  task automatic run_load(input string tag, input int base, input int n,
                          input bit stall, input int mid_start);
    int nw, nbytes, idx, guard, ph, s_cyc, exp_addr, exp_done;
    logic [31:0] exp_data;
    logic acc;
    nw = (n > POS) ? POS : n;
    nbytes = nw * 4;
    if (stim.size() == 0)
      for (int i = 0; i < nbytes; i++) stim.push_back(8'($urandom));
    clear_mon();
    @(posedge CLK); #1;
    start = 1'b1; base_addr = AW'(base); n_words = (AW+1)'(n);
    @(posedge CLK); s_cyc = cyc; #1;
    start = 1'b0; base_addr = AW'($urandom); n_words = (AW+1)'($urandom);
    idx = 0; guard = 0; ph = 0;
    while (idx < nbytes && guard < nbytes * 8 + 20) begin
      byte_valid = stall ? ((ph % 4) == 0 || (ph % 4) == 3) : 1'b1;
      ph++;
      byte_in = stim[idx];
      start = (mid_start >= 0 && idx == mid_start);
      @(negedge CLK);
      acc = byte_valid && byte_ready;
      @(posedge CLK); #1;
      if (acc) idx++;
      guard++;
    end
    start = 1'b0; byte_valid = 1'b0;
    chk({tag, " bytes_accepted"}, idx, nbytes);
    guard = 0;
    while (done_cyc.size() == 0 && guard < 20) begin
      @(posedge CLK); guard++;
    end
    @(negedge CLK); #1;
    chk({tag, " busy_after"}, busy, 1'b0);
    chk({tag, " err"}, err, (n > POS));
    chk({tag, " nwrites"}, we_cyc.size(), nw);
    for (int i = 0; i < nw && i < we_cyc.size(); i++) begin
      exp_addr = (base + i) % POS;
      exp_data = {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
      chk({tag, " waddr"}, we_addr[i], exp_addr);
      chk({tag, " wdata"}, we_data[i], exp_data);
      if (!stall)
        chk({tag, " we_cycle"}, we_cyc[i], s_cyc + 5 * (i + 1));
    end
    chk({tag, " done_count"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) begin
      exp_done = (nw > 0 && we_cyc.size() > 0) ? we_cyc[we_cyc.size()-1] + 1 : s_cyc + 1;
      chk({tag, " done_cycle"}, done_cyc[0], exp_done);
    end
    stim.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " byte_ready"}, byte_ready, 1'b0);
    chk({tag, " we"}, we, 1'b0);
    chk({tag, " waddr"}, waddr, '0);
    chk({tag, " wdata"}, wdata, '0);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " done"}, done, 1'b0);
    chk({tag, " err"}, err, 1'b0);
  endtask

  localparam logic [7:0] PROG [16] = '{
    8'h13, 8'h00, 8'hf0, 8'h0f, 8'h93, 8'h80, 8'hf0, 8'h0f,
    8'h13, 8'h01, 8'hf1, 8'h0f, 8'h93, 8'h81, 8'hf1, 8'h0f};
  localparam logic [31:0] PROG_W [4] = '{32'h0ff00013, 32'h0ff08093, 32'h0ff10113, 32'h0ff18193};

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    chk_all_zero("reset");
    RST_n = 1'b1;

    for (int i = 0; i < 16; i++) stim.push_back(PROG[i]);
    run_load("four_word", 0, 4, 1'b0, -1);
    for (int i = 0; i < 4 && i < we_data.size(); i++)
      chk("four_word const", we_data[i], PROG_W[i]);

    for (int i = 0; i < 16; i++) stim.push_back(PROG[i]);
    run_load("stalled", 0, 4, 1'b1, -1);
    for (int i = 0; i < 4 && i < we_data.size(); i++)
      chk("stalled const", we_data[i], PROG_W[i]);

    for (int r = 0; r < 6; r++)
      run_load("random", int'($urandom_range(0, POS-1)), int'($urandom_range(1, 6)),
               1'($urandom_range(0, 1)), -1);

    run_load("wrap", 1022, 3, 1'b0, -1);
    run_load("clamp", int'($urandom_range(0, POS-1)), 1025, 1'b0, -1);
    run_load("zero_len", 17, 0, 1'b0, -1);
    run_load("ignored_start", 100, 3, 1'b1, 5);

    clear_mon();
    @(posedge CLK); #1;
    start = 1'b1; base_addr = AW'(5); n_words = (AW+1)'(2);
    @(posedge CLK); #1;
    start = 1'b0; byte_valid = 1'b1; byte_in = 8'h3c;
    @(posedge CLK); #1;
    byte_in = 8'ha5;
    @(posedge CLK); #1;
    byte_valid = 1'b0;
    @(negedge CLK); #2;
    RST_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    chk("mid_reset no_write", we_cyc.size(), 0);
    RST_n = 1'b1;
    run_load("post_reset", 0, 2, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
